// File: rtl/chacha_block_counter_lanes.sv
// chacha_block_counter_lanes
//   Hands out ChaCha20 block counters to LANES parallel cores. Each batch
//   carries LANES consecutive counter values and is offered on a valid/ready
//   handshake. With WRAP_MODE=0 the counter stops at its top value and is
//   never reused. With WRAP_MODE=1 it wraps modulo 2^CTR_W.
//
// Ports
//   clk           rising-edge system clock
//   rst_n         asynchronous active-low reset
//   init          synchronous pulse: load init_ctr, clear statistics, start issuing
//   init_ctr      first counter value of the first batch
//   ctr_ready     core array accepts the current batch
//   ctr_valid     a batch is present on ctr_lanes
//   ctr_lanes     lane i at [i*CTR_W +: CTR_W] = ctr_base + i (mod 2^CTR_W)
//   lane_mask     bit i set when lane i has not run past the counter top
//   exhausted     sticky flag: counter space used up (WRAP_MODE=0 only)
//   wrapped       one-cycle pulse after accepting a batch whose base+LANES carried
//   blocks_issued usable lanes accepted since init, saturating at 0xFFFFFFFF

module chacha_block_counter_lanes #(
    parameter int CTR_W     = 32,
    parameter int LANES     = 4,
    parameter int WRAP_MODE = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   init,
    input  logic [CTR_W-1:0]       init_ctr,
    input  logic                   ctr_ready,
    output logic                   ctr_valid,
    output logic [LANES*CTR_W-1:0] ctr_lanes,
    output logic [LANES-1:0]       lane_mask,
    output logic                   exhausted,
    output logic                   wrapped,
    output logic [31:0]            blocks_issued
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        EXHAUSTED = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CTR_W-1:0] ctr_base;
    logic [CTR_W:0]   base_sum;
    logic             base_carry;
    logic             accept;
    logic             stop_here;
    logic [4:0]       usable;
    logic [32:0]      blocks_sum;
    logic [CTR_W:0]   lane_sum [LANES];

    // The sums are one bit wider than the counter. The top bit tells whether
    // a lane, or the next base, ran past 2^CTR_W-1.
    for (genvar i = 0; i < LANES; i++) begin : g_lane_sum
        assign lane_sum[i] = {1'b0, ctr_base} + (CTR_W+1)'(i);
    end

    assign base_sum   = {1'b0, ctr_base} + (CTR_W+1)'(LANES);
    assign base_carry = base_sum[CTR_W];
    assign accept     = (state == RUN) && ctr_ready;
    assign stop_here  = (WRAP_MODE == 0) && base_carry;
    assign ctr_valid  = (state == RUN);
    assign exhausted  = (state == EXHAUSTED);

    // Lanes and mask depend only on registered state, so they stay stable
    // under backpressure. They are not driven from ctr_ready. Outside RUN
    // they read zero.
    always_comb begin
        ctr_lanes = '0;
        lane_mask = '0;
        if (state == RUN) begin
            for (int i = 0; i < LANES; i++) begin
                ctr_lanes[i*CTR_W +: CTR_W] = lane_sum[i][CTR_W-1:0];
                lane_mask[i] = (WRAP_MODE != 0) || !lane_sum[i][CTR_W];
            end
        end
    end

    always_comb begin
        usable = '0;
        for (int i = 0; i < LANES; i++) begin
            usable = usable + 5'(lane_mask[i]);
        end
    end

    assign blocks_sum = {1'b0, blocks_issued} + 33'(usable);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // init wins from every state. The only other move is RUN -> EXHAUSTED,
    // taken when an accepted batch leaves no counter values in stop mode.
    always_comb begin
        state_next = state;
        if (init) begin
            state_next = RUN;
        end else if (accept && stop_here) begin
            state_next = EXHAUSTED;
        end
    end

    // On an init edge a coincident accept is discarded: it does not count
    // and does not advance the base.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_base      <= '0;
            blocks_issued <= '0;
            wrapped       <= 1'b0;
        end else if (init) begin
            ctr_base      <= init_ctr;
            blocks_issued <= '0;
            wrapped       <= 1'b0;
        end else begin
            wrapped <= 1'b0;
            if (accept) begin
                blocks_issued <= blocks_sum[32] ? 32'hFFFF_FFFF : blocks_sum[31:0];
                if (!stop_here) begin
                    ctr_base <= base_sum[CTR_W-1:0];
                    wrapped  <= base_carry;
                end
            end
        end
    end

endmodule

// File: tb/tb_chacha_block_counter_lanes.sv
// Testbench for chacha_block_counter_lanes.
// Runs two instances side by side and compares them with an arithmetic
// reference model:
//   dut_a: CTR_W=32, LANES=4, stop at the counter top
//   dut_b: CTR_W=64, LANES=4, wrap around

module tb_chacha_block_counter_lanes;

    logic          clk;
    logic          rst_n;
    logic          init;
    logic          ctr_ready;
    logic [31:0]   init_ctr_a;
    logic [63:0]   init_ctr_b;

    logic          valid_a, exh_a, wrap_a;
    logic [127:0]  lanes_a;
    logic [3:0]    mask_a;
    logic [31:0]   blocks_a;

    logic          valid_b, exh_b, wrap_b;
    logic [255:0]  lanes_b;
    logic [3:0]    mask_b;
    logic [31:0]   blocks_b;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state, one entry per instance (0 = dut_a, 1 = dut_b)
    bit              m_run    [2];
    bit              m_exh    [2];
    bit              m_wrap   [2];
    logic [64:0]     m_base   [2];
    longint unsigned m_blocks [2];

    chacha_block_counter_lanes #(.CTR_W(32), .LANES(4), .WRAP_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .init(init), .init_ctr(init_ctr_a),
        .ctr_ready(ctr_ready), .ctr_valid(valid_a), .ctr_lanes(lanes_a),
        .lane_mask(mask_a), .exhausted(exh_a), .wrapped(wrap_a),
        .blocks_issued(blocks_a)
    );

    chacha_block_counter_lanes #(.CTR_W(64), .LANES(4), .WRAP_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .init(init), .init_ctr(init_ctr_b),
        .ctr_ready(ctr_ready), .ctr_valid(valid_b), .ctr_lanes(lanes_b),
        .lane_mask(mask_b), .exhausted(exh_b), .wrapped(wrap_b),
        .blocks_issued(blocks_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int width_of(int d);
        return (d == 0) ? 32 : 64;
    endfunction

    function automatic logic [64:0] top_of(int d);
        return 65'd1 << width_of(d);
    endfunction

    function automatic logic [3:0] exp_mask(int d);
        logic [3:0] m;
        m = '0;
        if (m_run[d]) begin
            for (int i = 0; i < 4; i++) begin
                if (d == 1 || (m_base[d] + 65'(i)) < top_of(d)) m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic [255:0] exp_lanes(int d);
        logic [255:0] r;
        logic [64:0]  v;
        r = '0;
        if (m_run[d]) begin
            for (int i = 0; i < 4; i++) begin
                v = (m_base[d] + 65'(i)) % top_of(d);
                r = r | (256'(v) << (i * width_of(d)));
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: observed %h expected %h", tag, $time, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_run[d]    = 1'b0;
            m_exh[d]    = 1'b0;
            m_wrap[d]   = 1'b0;
            m_base[d]   = '0;
            m_blocks[d] = 0;
        end
    endtask

    task automatic model_clock(input bit i_init, input logic [31:0] ca,
                               input logic [63:0] cb, input bit rdy);
        logic [64:0] sum;
        for (int d = 0; d < 2; d++) begin
            if (i_init) begin
                m_run[d]    = 1'b1;
                m_exh[d]    = 1'b0;
                m_wrap[d]   = 1'b0;
                m_base[d]   = (d == 0) ? 65'(ca) : 65'(cb);
                m_blocks[d] = 0;
            end else begin
                m_wrap[d] = 1'b0;
                if (m_run[d] && rdy) begin
                    m_blocks[d] = m_blocks[d] + longint'($countones(exp_mask(d)));
                    if (m_blocks[d] > 64'hFFFF_FFFF) m_blocks[d] = 64'hFFFF_FFFF;
                    sum = m_base[d] + 65'd4;
                    if (d == 0 && sum >= top_of(d)) begin
                        m_run[d] = 1'b0;
                        m_exh[d] = 1'b1;
                    end else begin
                        m_wrap[d] = (sum >= top_of(d));
                        m_base[d] = sum % top_of(d);
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        checkOutput("a.valid",   256'(valid_a),  256'(m_run[0]));
        checkOutput("a.lanes",   256'(lanes_a),  exp_lanes(0));
        checkOutput("a.mask",    256'(mask_a),   256'(exp_mask(0)));
        checkOutput("a.exhaust", 256'(exh_a),    256'(m_exh[0]));
        checkOutput("a.blocks",  256'(blocks_a), 256'(m_blocks[0]));
        checkOutput("b.valid",   256'(valid_b),  256'(m_run[1]));
        checkOutput("b.lanes",   lanes_b,        exp_lanes(1));
        checkOutput("b.mask",    256'(mask_b),   256'(exp_mask(1)));
        checkOutput("b.exhaust", 256'(exh_b),    256'(m_exh[1]));
        checkOutput("b.wrapped", 256'(wrap_b),   256'(m_wrap[1]));
        checkOutput("b.blocks",  256'(blocks_b), 256'(m_blocks[1]));
    endtask

    // Called just after a falling edge. Drives inputs, checks the outputs
    // mid-cycle, then advances the model on the rising edge.
    task automatic applyStimulus(input bit i_init, input logic [31:0] ca,
                                 input logic [63:0] cb, input bit rdy);
        init       = i_init;
        init_ctr_a = ca;
        init_ctr_b = cb;
        ctr_ready  = rdy;
        #1;
        check_all();
        @(posedge clk);
        model_clock(i_init, ca, cb, rdy);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] ca;
        logic [63:0] cb;
        rst_n      = 1'b0;
        init       = 1'b0;
        ctr_ready  = 1'b0;
        init_ctr_a = '0;
        init_ctr_b = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Idle until init, then basic issue and backpressure
        applyStimulus(1'b0, 32'd0, 64'd0, 1'b1);
        applyStimulus(1'b1, 32'd1, 64'd1, 1'b1);
        applyStimulus(1'b0, 32'd0, 64'd0, 1'b1);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 32'd0, 64'd0, 1'b0);
        applyStimulus(1'b0, 32'd0, 64'd0, 1'b1);
        applyStimulus(1'b0, 32'd0, 64'd0, 1'b0);

        // Exhaustion on dut_a, wrap-around on dut_b
        applyStimulus(1'b1, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        applyStimulus(1'b0, 32'd0, 64'd0, 1'b1);
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 32'd0, 64'd0, 1'b1);

        // Restart from exhaustion, then init coincident with an accept
        applyStimulus(1'b1, 32'd0, 64'd0, 1'b1);
        applyStimulus(1'b0, 32'd0, 64'd0, 1'b0);
        applyStimulus(1'b1, 32'd100, 64'd200, 1'b1);
        applyStimulus(1'b0, 32'd0, 64'd0, 1'b1);
        applyStimulus(1'b0, 32'd0, 64'd0, 1'b1);

        // Asynchronous reset in the middle of a cycle
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 32'd0, 64'd0, 1'b1);

        // Random traffic, with init values biased toward the counter top
        for (int k = 0; k < 400; k++) begin
            ca = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 9) : $urandom;
            cb = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, 32'hFFFF_FFFF - $urandom_range(0, 9)}
                                             : {$urandom, $urandom};
            applyStimulus($urandom_range(0, 15) == 0, ca, cb, $urandom_range(0, 2) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
